// File: rtl/adder_pkg.sv
// Shared elaboration helpers for the segmented adder family.
//   nseg(width, seg_w)       : number of segments, ceil(width / seg_w)
//   last_seg_w(width, seg_w) : width of the top (possibly narrower) segment
//   cwidth(w)                : carry-wire size of the combinational adder at width w
package adder_pkg;

  function automatic int nseg(input int width, input int seg_w);
    return (width + seg_w - 1) / seg_w;
  endfunction

  function automatic int last_seg_w(input int width, input int seg_w);
    return width - (nseg(width, seg_w) - 1) * seg_w;
  endfunction

  // One carry per 4-bit block, one per leftover bit, plus the carry-in.
  function automatic int cwidth(input int w);
    return w / 4 + w % 4 + 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Combinational adder: {c_out, s} = in_a + in_b + c_in.
// Resolved as 4-bit blocks followed by single-bit cells for the remainder;
// CWIDTH must equal adder_pkg::cwidth(WIDTH).
// Ports:
//   in_a, in_b : WIDTH-bit operands
//   c_in       : carry-in
//   s          : WIDTH-bit sum
//   c_out      : carry out of bit WIDTH-1
module adder #(
  parameter int WIDTH  = 4,
  parameter int CWIDTH = 2
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int NB = WIDTH / 4;
  localparam int NR = WIDTH % 4;

  logic [CWIDTH-1:0] c;

  // Ripple kept inside one process so the carry chain is a single comb block.
  always_comb begin
    logic [4:0] blk;
    blk  = '0;
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < NB; i++) begin
      blk          = {1'b0, in_a[4*i +: 4]} + {1'b0, in_b[4*i +: 4]} + {4'b0, c[i]};
      s[4*i +: 4]  = blk[3:0];
      c[i+1]       = blk[4];
    end
    for (int j = 0; j < NR; j++) begin
      s[4*NB+j]   = in_a[4*NB+j] ^ in_b[4*NB+j] ^ c[NB+j];
      c[NB+j+1]   = (in_a[4*NB+j] & in_b[4*NB+j]) |
                    (c[NB+j] & (in_a[4*NB+j] ^ in_b[4*NB+j]));
    end
  end

  assign c_out = c[CWIDTH-1];

endmodule

// File: rtl/adder_seg_stage.sv
// One registered stage of the segmented adder. Resolves bits [LO +: SW],
// writing the segment sum over the operand-A bits it consumed, so x carries
// resolved sum bits below LO+SW and untouched A bits above. y carries the
// (already conditioned) B operand unchanged.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ld_i          : stage enable (stage empty or downstream advancing)
//   v_i, x_i, y_i, c_i, tag_i : beat from the previous stage
//   v_o, x_o, y_o, c_o, tag_o : registered beat for the next stage
module adder_seg_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 106,
  parameter int TAG_W = 8,
  parameter int LO    = 0,
  parameter int SW    = 27
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             c_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             v_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             c_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CW = cwidth(SW);

  logic [SW-1:0]    seg_sum;
  logic             seg_cout;
  logic [WIDTH-1:0] x_d;
  logic             v_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             c_q;
  logic [TAG_W-1:0] tag_q;

  adder #(
    .WIDTH (SW),
    .CWIDTH(CW)
  ) u_adder (
    .in_a (x_i[LO +: SW]),
    .in_b (y_i[LO +: SW]),
    .c_in (c_i),
    .s    (seg_sum),
    .c_out(seg_cout)
  );

  always_comb begin
    x_d             = x_i;
    x_d[LO +: SW]   = seg_sum;
  end

  // Bubbles are loaded too (v_i = 0), which is what lets them collapse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q   <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      c_q   <= 1'b0;
      tag_q <= '0;
    end else if (ld_i) begin
      v_q   <= v_i;
      x_q   <= x_d;
      y_q   <= y_i;
      c_q   <= seg_cout;
      tag_q <= tag_i;
    end
  end

  assign v_o   = v_q;
  assign x_o   = x_q;
  assign y_o   = y_q;
  assign c_o   = c_q;
  assign tag_o = tag_q;

endmodule

// File: rtl/pipe_seg_adder.sv
// Pipelined segmented add/subtract with valid/ready flow control.
// {c_out, s} = A + (sub ? ~B : B) + (c_in ^ sub), one SEG_W-bit segment per
// stage, NSEG stages, one operation per cycle, sideband tag carried along.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid / in_ready    : input handshake (in_ready is comb on out_ready)
//   in_a, in_b, c_in, sub  : operands, carry/borrow-in, subtract select
//   in_tag                 : sideband tag
//   out_valid / out_ready  : output handshake
//   s, c_out, out_tag      : result, carry-out (sub: 1 = no borrow), tag
module pipe_seg_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 106,
  parameter int SEG_W = 27,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             c_in,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  // Index k is the input of stage k; index NSEG is the pipeline output.
  logic [NSEG:0]    v;
  logic [NSEG:0]    en;
  logic [NSEG:0]    c;
  logic [WIDTH-1:0] x   [NSEG+1];
  logic [WIDTH-1:0] y   [NSEG+1];
  logic [TAG_W-1:0] tag [NSEG+1];

  assign v[0]   = in_valid;
  assign x[0]   = in_a;
  assign y[0]   = sub ? ~in_b : in_b;
  assign c[0]   = c_in ^ sub;
  assign tag[0] = in_tag;

  // A stage may load when it is empty or when the stage after it loads too.
  always_comb begin
    en       = '0;
    en[NSEG] = out_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      en[k] = !v[k+1] | en[k+1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int SW = (k == NSEG - 1) ? last_seg_w(WIDTH, SEG_W) : SEG_W;

    adder_seg_stage #(
      .WIDTH(WIDTH),
      .TAG_W(TAG_W),
      .LO   (k * SEG_W),
      .SW   (SW)
    ) u_stage (
      .clk_i (clk),
      .rst_ni(rst_n),
      .ld_i  (en[k]),
      .v_i   (v[k]),
      .x_i   (x[k]),
      .y_i   (y[k]),
      .c_i   (c[k]),
      .tag_i (tag[k]),
      .v_o   (v[k+1]),
      .x_o   (x[k+1]),
      .y_o   (y[k+1]),
      .c_o   (c[k+1]),
      .tag_o (tag[k+1])
    );
  end

  assign in_ready  = en[0];
  assign out_valid = v[NSEG];
  assign s         = x[NSEG];
  assign c_out     = c[NSEG];
  assign out_tag   = tag[NSEG];

endmodule

// File: tb/tb_pipe_seg_adder.sv
module tb_pipe_seg_adder;
  localparam int WIDTH = 106;
  localparam int SEG_W = 27;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             c_in;
  logic             sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic [TAG_W-1:0] out_tag;

  pipe_seg_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .c_in(c_in), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [WIDTH:0]   sum;
  } exp_t;

  exp_t             q[$];
  exp_t             e;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               n_acc = 0;
  logic             held = 1'b0;
  logic [WIDTH-1:0] h_s;
  logic             h_c;
  logic [TAG_W-1:0] h_tag;

  // Reference: plain (WIDTH+1)-bit arithmetic on whole operands.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic ci, input logic sb);
    logic [WIDTH:0] bb;
    bb = {1'b0, (sb ? ~b : b)};
    return {1'b0, a} + bb + {{WIDTH{1'b0}}, ci ^ sb};
  endfunction

  function automatic logic [WIDTH-1:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                     input logic sb, input logic [TAG_W-1:0] tg, input logic vld);
    in_a = a; in_b = b; c_in = ci; sub = sb; in_tag = tg; in_valid = vld;
  endtask

  // Scoreboard / compare process: decisions made at negedge reflect the
  // handshake that completes at the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_s",         128'(s),         128'(0));
      chk("rst_c_out",     128'(c_out),     128'(0));
      chk("rst_out_tag",   128'(out_tag),   128'(0));
      chk("rst_in_ready",  128'(in_ready),  128'(1));
    end else begin
      if (held) begin
        chk("stall_valid", 128'(out_valid), 128'(1));
        chk("stall_s",     128'(s),         128'(h_s));
        chk("stall_c_out", 128'(c_out),     128'(h_c));
        chk("stall_tag",   128'(out_tag),   128'(h_tag));
      end
      if (out_valid && out_ready) begin
        chk("pop_expected", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("res_tag", 128'(out_tag), 128'(e.tag));
          chk("res_sum", 128'({c_out, s}), 128'(e.sum));
        end
      end
      held  = out_valid && !out_ready;
      h_s   = s;
      h_c   = c_out;
      h_tag = out_tag;
      if (in_valid && in_ready) begin
        q.push_back('{in_tag, ref_sum(in_a, in_b, c_in, sub)});
        n_acc++;
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] neg2;
    int               t;
    int               acc0;

    ones = '1;
    neg2 = ones - 1'b1;

    // Reset with random inputs
    rst_n = 1'b0;
    out_ready = 1'b1;
    put(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      put(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_out_valid", 128'(out_valid), 128'(0));
    end

    // Full carry ripple through every segment
    @(posedge clk); #1;
    put(ones, '0, 1'b1, 1'b0, 8'h5A, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("carry_latency", 128'(out_valid), 128'(i == 4));
    end
    chk("carry_s",     128'(s),       128'(0));
    chk("carry_c_out", 128'(c_out),   128'(1));
    chk("carry_tag",   128'(out_tag), 128'(8'h5A));

    // Subtract, back to back
    @(posedge clk); #1;
    put(106'd5, 106'd7, 1'b0, 1'b1, 8'h01, 1'b1);
    @(posedge clk); #1;
    put(106'd7, 106'd5, 1'b0, 1'b1, 8'h02, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("sub1_valid", 128'(out_valid), 128'(1));
    chk("sub1_s",     128'(s),         128'(neg2));
    chk("sub1_c_out", 128'(c_out),     128'(0));
    @(negedge clk);
    chk("sub2_valid", 128'(out_valid), 128'(1));
    chk("sub2_s",     128'(s),         128'(2));
    chk("sub2_c_out", 128'(c_out),     128'(1));

    // Backpressure: 6 offered, 4 fit, then drain in order
    @(posedge clk); #1;
    out_ready = 1'b0;
    t = 1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      put(rnd(), rnd(), 1'(t >> 1), 1'(t), 8'(t), 1'(t <= 6));
      @(negedge clk);
      if (in_valid && in_ready) t++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", 128'(t - 1), 128'(4));
    @(negedge clk);
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_head_vld", 128'(out_valid), 128'(1));
    chk("bp_head_tag", 128'(out_tag), 128'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && t <= 6; cyc++) begin
      put(rnd(), rnd(), 1'(t >> 1), 1'(t), 8'(t), 1'b1);
      @(negedge clk);
      if (in_ready) t++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 128'(t), 128'(7));
    for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) @(negedge clk);
    chk("bp_drained", 128'(q.size()), 128'(0));

    // Reset mid-stream: in-flight beats must never emerge
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(rnd(), rnd(), 1'b0, 1'b0, 8'(8'hE1 + i), 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_valid_before", 128'(out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_valid_drop", 128'(out_valid), 128'(0));
    chk("mid_s_zero",     128'(s),         128'(0));
    chk("mid_tag_zero",   128'(out_tag),   128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("mid_no_ghost", 128'(out_valid), 128'(0));
    end

    // Random traffic with random valid and ready
    acc0 = n_acc;
    for (int cyc = 0; cyc < 60000 && (n_acc - acc0) < 10000; cyc++) begin
      @(posedge clk); #1;
      put(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    chk("rand_beats", 128'((n_acc - acc0) >= 10000), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) @(negedge clk);
    chk("final_drain", 128'(q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
